round_controller: RTL and testbench
===================================

// Module: round_controller
// PURPOSE
//  Match/round sequencer downstream of health management; consumes per-player health and the
//  reset request. Runs INTRO countdown, FIGHT timer, KO/timeout judgement and best-of-N scoring.
//  Drives winner state (menu, music), a round reset pulse (physics, health, collision) and
//  freeze (movement handlers). All state advances on the 20 Hz game-tick enable.
// PARAMETERS
//  TICKS_PER_SEC  20  game ticks per displayed second
//  ROUND_SECONDS  60  fight timer start value (1..99)
//  INTRO_TICKS    60  freeze time before FIGHT
//  KO_TICKS       40  freeze time after round decided
//  RST_TICKS      2   length of round_reset assertion, in ticks
//  HOLD_TICKS     40  consecutive ticks reset_req must be held for a match reset
//  ROUNDS_TO_WIN  2   round wins that end the match (1..3)
// PORTS
//  clk          input   1  100 MHz system clock
//  reset        input   1  asynchronous, active-low (0 = reset)
//  tick         input   1  one-clk enable at 20 Hz; all non-reset updates gated by it
//  health_1     input   9  player 1 health; 0 = knocked out
//  health_2     input   9  player 2 health
//  reset_req    input   1  level; (attack btn and match over) or reset switch
//  winner       output  2  00 fighting/none, 01 P1 won, 10 P2 won, 11 draw
//  round_reset  output  1  resets physics/health/collision for a new round
//  freeze       output  1  movement handlers ignore inputs while high
//  round_time   output  7  seconds remaining, 0..ROUND_SECONDS
//  p1_rounds    output  2  rounds won by P1
//  p2_rounds    output  2  rounds won by P2
//  match_over   output  1  high in MATCH_OVER
// BEHAVIOUR
//  Async reset: state=RST_RND, all counters 0, winner=00, round_reset=1, freeze=1,
//   round_time=ROUND_SECONDS, p1/p2_rounds=0, match_over=0. Outputs are registered.
//  FSM (transitions on clk with tick=1):
//   RST_RND: round_reset=1, freeze=1; after RST_TICKS ticks -> INTRO, round_reset=0.
//   INTRO: freeze=1, winner=00; after INTRO_TICKS ticks -> FIGHT, round_time=ROUND_SECONDS.
//   FIGHT: freeze=0; sub-counter decrements round_time every TICKS_PER_SEC ticks, saturates at 0.
//    Both healths 0 on the same tick -> winner=11; only health_1==0 -> 10; only health_2==0 -> 01.
//    round_time==0, both alive: lower health loses; equal -> draw (see CONFIGURATION).
//    KO check precedes timeout on the same tick. Decision -> KO.
//   KO: freeze=1, winner held; winning player's round count +1 on entry (draw: none).
//    After KO_TICKS: a count == ROUNDS_TO_WIN -> MATCH_OVER, else -> RST_RND (winner=00).
//   MATCH_OVER: freeze=1, match_over=1, winner holds match winner; stays until match reset.
//  Match reset: hold counter counts ticks with reset_req=1, clears on any tick with 0,
//   saturates. When it reaches HOLD_TICKS in any state: rounds cleared, winner=00,
//   match_over=0, -> RST_RND. Overrides every other transition that tick.
//  Round counters saturate at 3; never both increment on the same KO.
//  Health inputs are sampled only in FIGHT; changes in other states are ignored.
//  Reset asserted mid-operation returns to reset values immediately; no partial round state kept.
// CONFIGURATION
//  SUDDEN_DEATH_EN defined: timeout with equal health does not draw; FIGHT continues with
//   round_time held at 0 until healths differ (lower loses) or a KO occurs.
//  Undefined: timeout with equal health -> winner=11, no round awarded, KO then RST_RND.
// TESTING
//  Reset low 5 clks, release -> round_reset high 2 ticks, freeze high 62 ticks, then freeze=0, round_time=60.
//  FIGHT, health_2 -> 0 at tick N -> tick N: winner=01, freeze=1, p1_rounds=1; 40 ticks later round_reset=1.
//  P1 wins two rounds -> MATCH_OVER: match_over=1, winner=01; reset_req held 39 ticks no change, tick 40 -> RST_RND, counts 0.
//  Same-tick health_1=health_2=0 -> winner=11, neither count changes.
//  Timeout, health_1=50/health_2=80 -> winner=10; equal 80/80 -> 11 (macro off) or FIGHT continues at round_time=0 (macro on).
//  reset_req pulses 30 ticks, drops 1 tick, 30 ticks again -> no match reset.

Source files
------------

// File: rtl/round_controller.sv
// Match/round sequencer: intro countdown, fight timer, KO/timeout judgement, best-of-N scoring.
// Optional macro SUDDEN_DEATH_EN: an equal-health timeout keeps fighting instead of drawing.
module round_controller #(
  parameter int TICKS_PER_SEC = 20,
  parameter int ROUND_SECONDS = 60,
  parameter int INTRO_TICKS   = 60,
  parameter int KO_TICKS      = 40,
  parameter int RST_TICKS     = 2,
  parameter int HOLD_TICKS    = 40,
  parameter int ROUNDS_TO_WIN = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic [8:0] health_1,
  input  logic [8:0] health_2,
  input  logic       reset_req,
  output logic [1:0] winner,
  output logic       round_reset,
  output logic       freeze,
  output logic [6:0] round_time,
  output logic [1:0] p1_rounds,
  output logic [1:0] p2_rounds,
  output logic       match_over,
  output logic [2:0] fsm_state
);

  localparam logic [2:0] ST_RST_RND    = 3'd0;
  localparam logic [2:0] ST_INTRO      = 3'd1;
  localparam logic [2:0] ST_FIGHT      = 3'd2;
  localparam logic [2:0] ST_KO         = 3'd3;
  localparam logic [2:0] ST_MATCH_OVER = 3'd4;

  logic [2:0] state;
  logic [7:0] cnt;
  logic [7:0] sub;
  logic [7:0] hold;
  logic       match_rst;
  logic       fight_done;
  logic [1:0] fight_win;

  assign fsm_state = state;

  // The hold counter passes through HOLD_TICKS-1 exactly once per unbroken press run.
  assign match_rst = reset_req && (hold == 8'(HOLD_TICKS - 1));

  always_comb begin
    fight_done = 1'b0;
    fight_win  = 2'b00;
    if (health_1 == 9'd0 && health_2 == 9'd0) begin
      fight_done = 1'b1;
      fight_win  = 2'b11;
    end else if (health_1 == 9'd0) begin
      fight_done = 1'b1;
      fight_win  = 2'b10;
    end else if (health_2 == 9'd0) begin
      fight_done = 1'b1;
      fight_win  = 2'b01;
    end else if (round_time == 7'd0) begin
      if (health_1 < health_2) begin
        fight_done = 1'b1;
        fight_win  = 2'b10;
      end else if (health_2 < health_1) begin
        fight_done = 1'b1;
        fight_win  = 2'b01;
      end else begin
`ifdef SUDDEN_DEATH_EN
        fight_done = 1'b0;
`else
        fight_done = 1'b1;
        fight_win  = 2'b11;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_RST_RND;
      cnt         <= '0;
      sub         <= '0;
      hold        <= '0;
      winner      <= 2'b00;
      round_reset <= 1'b1;
      freeze      <= 1'b1;
      round_time  <= 7'(ROUND_SECONDS);
      p1_rounds   <= 2'd0;
      p2_rounds   <= 2'd0;
      match_over  <= 1'b0;
    end else if (tick) begin
      if (!reset_req)
        hold <= '0;
      else if (hold != 8'(HOLD_TICKS))
        hold <= hold + 8'd1;

      if (match_rst) begin
        state       <= ST_RST_RND;
        cnt         <= '0;
        sub         <= '0;
        winner      <= 2'b00;
        round_reset <= 1'b1;
        freeze      <= 1'b1;
        round_time  <= 7'(ROUND_SECONDS);
        p1_rounds   <= 2'd0;
        p2_rounds   <= 2'd0;
        match_over  <= 1'b0;
      end else begin
        case (state)
          ST_RST_RND: begin
            round_reset <= 1'b1;
            freeze      <= 1'b1;
            if (cnt == 8'(RST_TICKS - 1)) begin
              state       <= ST_INTRO;
              cnt         <= '0;
              round_reset <= 1'b0;
              winner      <= 2'b00;
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_INTRO: begin
            freeze <= 1'b1;
            winner <= 2'b00;
            if (cnt == 8'(INTRO_TICKS - 1)) begin
              state      <= ST_FIGHT;
              cnt        <= '0;
              sub        <= '0;
              freeze     <= 1'b0;
              round_time <= 7'(ROUND_SECONDS);
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_FIGHT: begin
            // KO and timeout are judged on the pre-tick timer value.
            if (fight_done) begin
              state  <= ST_KO;
              cnt    <= '0;
              freeze <= 1'b1;
              winner <= fight_win;
              if (fight_win == 2'b01 && p1_rounds != 2'd3)
                p1_rounds <= p1_rounds + 2'd1;
              if (fight_win == 2'b10 && p2_rounds != 2'd3)
                p2_rounds <= p2_rounds + 2'd1;
            end else if (sub == 8'(TICKS_PER_SEC - 1)) begin
              sub <= '0;
              if (round_time != 7'd0)
                round_time <= round_time - 7'd1;
            end else begin
              sub <= sub + 8'd1;
            end
          end
          ST_KO: begin
            freeze <= 1'b1;
            if (cnt == 8'(KO_TICKS - 1)) begin
              cnt <= '0;
              if (p1_rounds == 2'(ROUNDS_TO_WIN) || p2_rounds == 2'(ROUNDS_TO_WIN)) begin
                state      <= ST_MATCH_OVER;
                match_over <= 1'b1;
              end else begin
                state       <= ST_RST_RND;
                winner      <= 2'b00;
                round_reset <= 1'b1;
                round_time  <= 7'(ROUND_SECONDS);
              end
            end else begin
              cnt <= cnt + 8'd1;
            end
          end
          ST_MATCH_OVER: begin
            freeze     <= 1'b1;
            match_over <= 1'b1;
          end
          default: begin
            state       <= ST_RST_RND;
            cnt         <= '0;
            round_reset <= 1'b1;
            freeze      <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: round flow, scoring, timeout, match reset, async reset.
module tb_round_controller;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic [8:0] health_1 = 9'd100;
  logic [8:0] health_2 = 9'd100;
  logic       reset_req = 1'b0;
  logic [1:0] winner;
  logic       round_reset;
  logic       freeze;
  logic [6:0] round_time;
  logic [1:0] p1_rounds;
  logic [1:0] p2_rounds;
  logic       match_over;
  logic [2:0] fsm_state;

  int checks = 0;
  int errors = 0;

  round_controller dut (
    .clk(clk), .reset(reset), .tick(tick),
    .health_1(health_1), .health_2(health_2), .reset_req(reset_req),
    .winner(winner), .round_reset(round_reset), .freeze(freeze),
    .round_time(round_time), .p1_rounds(p1_rounds), .p2_rounds(p2_rounds),
    .match_over(match_over), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One tick pulse spanning exactly one rising edge; returns at a falling edge.
  task automatic do_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk) tick = 1'b1;
      @(negedge clk) tick = 1'b0;
    end
  endtask

  initial begin
    repeat (5) @(negedge clk);
    chk("rst_winner", winner, 0);
    chk("rst_round_reset", round_reset, 1);
    chk("rst_freeze", freeze, 1);
    chk("rst_round_time", round_time, 60);
    chk("rst_p1", p1_rounds, 0);
    chk("rst_p2", p2_rounds, 0);
    chk("rst_match_over", match_over, 0);
    chk("rst_state", fsm_state, 0);
    reset = 1'b1;

    do_ticks(1);
    chk("rr_tick1", round_reset, 1);
    do_ticks(1);
    chk("rr_tick2", round_reset, 0);
    do_ticks(59);
    chk("intro_freeze61", freeze, 1);
    do_ticks(1);
    chk("fight_freeze", freeze, 0);
    chk("fight_time", round_time, 60);
    chk("fight_state", fsm_state, 2);
    do_ticks(20);
    chk("time_dec", round_time, 59);

    health_2 = 9'd0;
    do_ticks(1);
    chk("ko1_winner", winner, 1);
    chk("ko1_freeze", freeze, 1);
    chk("ko1_p1", p1_rounds, 1);
    health_2 = 9'd100;
    health_1 = 9'd0;
    do_ticks(1);
    chk("ko_ignore_health", p2_rounds, 0);
    chk("ko_winner_held", winner, 1);
    health_1 = 9'd100;
    do_ticks(38);
    chk("ko_rr_39", round_reset, 0);
    do_ticks(1);
    chk("ko_rr_40", round_reset, 1);
    chk("ko_winner_clr", winner, 0);

    do_ticks(62);
    chk("r2_state", fsm_state, 2);
    health_2 = 9'd0;
    do_ticks(1);
    chk("ko2_p1", p1_rounds, 2);
    health_2 = 9'd100;
    do_ticks(40);
    chk("mo_flag", match_over, 1);
    chk("mo_winner", winner, 1);
    chk("mo_state", fsm_state, 4);

    reset_req = 1'b1;
    do_ticks(39);
    chk("hold39_mo", match_over, 1);
    chk("hold39_p1", p1_rounds, 2);
    do_ticks(1);
    chk("hold40_mo", match_over, 0);
    chk("hold40_p1", p1_rounds, 0);
    chk("hold40_winner", winner, 0);
    chk("hold40_rr", round_reset, 1);
    chk("hold40_state", fsm_state, 0);
    reset_req = 1'b0;

    do_ticks(62);
    health_1 = 9'd0;
    health_2 = 9'd0;
    do_ticks(1);
    chk("draw_winner", winner, 3);
    chk("draw_p1", p1_rounds, 0);
    chk("draw_p2", p2_rounds, 0);
    health_1 = 9'd100;
    health_2 = 9'd100;
    do_ticks(40);
    chk("draw_rr", round_reset, 1);
    chk("draw_state", fsm_state, 0);

    do_ticks(62);
    health_1 = 9'd50;
    health_2 = 9'd80;
    do_ticks(1200);
    chk("to_time0", round_time, 0);
    chk("to_pending", winner, 0);
    do_ticks(1);
    chk("to_winner", winner, 2);
    chk("to_p2", p2_rounds, 1);

    do_ticks(40 + 62);
    health_1 = 9'd80;
    health_2 = 9'd80;
    do_ticks(1201);
`ifdef SUDDEN_DEATH_EN
    chk("sd_winner", winner, 0);
    chk("sd_state", fsm_state, 2);
    chk("sd_time", round_time, 0);
    health_1 = 9'd70;
    do_ticks(1);
    chk("sd_decide", winner, 2);
    chk("sd_p2", p2_rounds, 2);
    do_ticks(40);
    chk("sd_mo", match_over, 1);
`else
    chk("eq_winner", winner, 3);
    chk("eq_p2", p2_rounds, 1);
    health_1 = 9'd100;
    health_2 = 9'd100;
    do_ticks(40 + 62);
    chk("eq_next_fight", fsm_state, 2);
`endif

    reset_req = 1'b1;
    do_ticks(30);
    reset_req = 1'b0;
    do_ticks(1);
    reset_req = 1'b1;
    do_ticks(30);
`ifdef SUDDEN_DEATH_EN
    chk("pulse_state", fsm_state, 4);
    chk("pulse_mo", match_over, 1);
`else
    chk("pulse_state", fsm_state, 2);
    chk("pulse_time", round_time, 57);
`endif
    do_ticks(10);
    chk("hold_again_state", fsm_state, 0);
    chk("hold_again_p2", p2_rounds, 0);
    reset_req = 1'b0;

    do_ticks(62);
    health_1 = 9'd0;
    do_ticks(1);
    chk("mid_p2", p2_rounds, 1);
    health_1 = 9'd100;
    @(negedge clk) reset = 1'b0;
    #1;
    chk("async_p2", p2_rounds, 0);
    chk("async_winner", winner, 0);
    chk("async_freeze", freeze, 1);
    chk("async_rr", round_reset, 1);
    chk("async_state", fsm_state, 0);
    chk("async_time", round_time, 60);
    @(negedge clk) reset = 1'b1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
